// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: pipeline enable/clear sequencer for load-use, redirect and data-memory freezes
module hazard_stall_ctrl #(
  parameter int MEM_LAT = 3,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             ex_redirect,
  input  logic             mem_req,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_clear,
  output logic             id_ex_en,
  output logic             id_ex_clear,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             mem_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int WW = $clog2(MEM_LAT) + 1;
  localparam int LOAD = MEM_LAT > 2 ? MEM_LAT - 3 : 0;
  localparam logic MS_EN = MEM_LAT > 1;
  localparam logic USE_WAIT = MEM_LAT > 2;
  localparam logic SHORT = MEM_LAT == 2;
  typedef enum logic {RUN, MEM_WAIT} state_t;
  state_t state, state_n;
  logic [WW-1:0] wait_cnt, wait_n;
  logic served, served_n;
  logic lu, mstall, adv, stl, fl;
  assign lu = ex_memread & (ex_rd != 5'd0) &
              ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
  assign mstall = mem_req & ~served & MS_EN;
  // Stage controls: the RUN cycle that raises mstall counts as a frozen cycle together with
  // MEM_WAIT, so a freeze lasts MEM_LAT-1 cycles and the release cycle follows with served set
  always_comb begin
    adv = ~rst & (state == RUN) & ~mstall;
    stl = adv & lu & ~ex_redirect;
    fl = adv & ex_redirect;
    pc_en = adv & ~stl;
    if_id_en = adv & ~stl;
    if_id_clear = rst | fl;
    id_ex_en = adv;
    id_ex_clear = rst | fl | stl;
    ex_mem_en = adv;
    mem_wb_en = adv;
    mem_busy = ~rst & (state == MEM_WAIT);
  end
  // Next-state: start a freeze on an unserved memory access, count down, then release once
  always_comb begin
    state_n = state;
    wait_n = wait_cnt;
    served_n = served;
    if (state == RUN) begin
      state_n = mstall & USE_WAIT ? MEM_WAIT : RUN;
      wait_n = mstall ? WW'(LOAD) : wait_cnt;
      served_n = mstall & SHORT;
    end else begin
      state_n = wait_cnt == '0 ? RUN : MEM_WAIT;
      wait_n = wait_cnt == '0 ? wait_cnt : wait_cnt - 1'b1;
      served_n = wait_cnt == '0;
    end
  end
  // State, served flag and performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      wait_cnt <= '0;
      served <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_n;
      wait_cnt <= wait_n;
      served <= served_n;
      stall_cnt <= stall_cnt + CNT_W'(!pc_en);
      flush_cnt <= flush_cnt + CNT_W'(fl);
    end
  end
endmodule
